// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the PC/nPC fetch sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } seq_state_t;

   localparam logic [31:0] INSN_BYTES = 32'd4;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_npc_regs.sv
// Paired PC/nPC register: one load enable, synchronous reset to parameter values.
module pc_npc_regs #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        load,
   input  logic [31:0] pc_next,
   input  logic [31:0] npc_next,
   output logic [31:0] pc,
   output logic [31:0] npc
);

   // Both registers update together so pc/npc can never be observed half-advanced.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc  <= RESET_PC;
         npc <= RESET_NPC;
      end else if (load) begin
         pc  <= pc_next;
         npc <= npc_next;
      end
   end

endmodule

// File: rtl/pc_npc_sequencer.sv
// Fetch-stage PC/nPC sequencer with delayed-branch semantics, stall hold,
// exception redirect with a one-cycle flush, and a one-cycle boot state.
module pc_npc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] RESET_NPC  = 32'h0000_0004,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             hazard_stall,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic             exception_req,
   output logic [31:0]      pc,
   output logic [31:0]      npc,
   output logic             fetch_valid,
   output logic             delay_slot,
   output logic [CNT_W-1:0] stall_count,
   output logic             seq_error
);

   seq_state_t       state_q, state_d;
   logic             load;
   logic [31:0]      pc_d, npc_d;
   logic             ds_d, err_d;
   logic [CNT_W-1:0] cnt_d;
   logic             redirect;
   logic [31:0]      target;
   logic [31:0]      vec;

   assign redirect    = branch_taken | jump;
   assign target      = align_word(branch_taken ? branch_target : jump_target);
   assign vec         = align_word(EXC_VECTOR);
   assign fetch_valid = (state_q == RUN);

   pc_npc_regs #(
      .RESET_PC  (RESET_PC),
      .RESET_NPC (RESET_NPC)
   ) u_regs (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (load),
      .pc_next  (pc_d),
      .npc_next (npc_d),
      .pc       (pc),
      .npc      (npc)
   );

   // Next-state, next PC/nPC and status flags; RUN inputs are priority-ordered.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      pc_d    = pc;
      npc_d   = npc;
      ds_d    = delay_slot;
      err_d   = seq_error;
      cnt_d   = stall_count;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (exception_req) begin
               load    = 1'b1;
               pc_d    = vec;
               npc_d   = vec + INSN_BYTES;
               ds_d    = 1'b0;
               state_d = FLUSH;
            end else if (hazard_stall) begin
               if (stall_count != '1)
                  cnt_d = stall_count + 1'b1;
            end else if (redirect && !delay_slot) begin
               load  = 1'b1;
               pc_d  = npc;
               npc_d = target;
               ds_d  = 1'b1;
            end else begin
               // A redirect inside a delay slot is dropped but still flagged.
               if (redirect)
                  err_d = 1'b1;
               load  = 1'b1;
               pc_d  = npc;
               npc_d = npc + INSN_BYTES;
               ds_d  = 1'b0;
            end
         end
         FLUSH: begin
            if (exception_req) begin
               load  = 1'b1;
               pc_d  = vec;
               npc_d = vec + INSN_BYTES;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State and status registers; Reset dominates every state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= BOOT;
         delay_slot  <= 1'b0;
         seq_error   <= 1'b0;
         stall_count <= '0;
      end else begin
         state_q     <= state_d;
         delay_slot  <= ds_d;
         seq_error   <= err_d;
         stall_count <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Self-checking bench for pc_npc_sequencer against a behavioural model.
module tb_pc_npc_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        hazard_stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        exception_req;
   logic [31:0] pc, npc;
   logic        fetch_valid, delay_slot, seq_error;
   logic [15:0] stall_count;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: mode 0=booting, 1=running, 2=flushing.
   int          m_mode;
   logic [31:0] m_pc, m_npc;
   bit          m_ds, m_err;
   int          m_stalls;

   always #5 Clk = ~Clk;

   pc_npc_sequencer dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .hazard_stall  (hazard_stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .exception_req (exception_req),
      .pc            (pc),
      .npc           (npc),
      .fetch_valid   (fetch_valid),
      .delay_slot    (delay_slot),
      .stall_count   (stall_count),
      .seq_error     (seq_error)
   );

   // Advance the model by one clock using the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic [31:0] tgt;
      if (Reset) begin
         m_mode = 0; m_pc = 32'h0; m_npc = 32'h4; m_ds = 0; m_err = 0; m_stalls = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         if (exception_req) begin m_pc = 32'h80; m_npc = 32'h84; end
         else m_mode = 1;
      end else if (exception_req) begin
         m_pc = 32'h80; m_npc = 32'h84; m_ds = 0; m_mode = 2;
      end else if (hazard_stall) begin
         if (m_stalls < 65535) m_stalls = m_stalls + 1;
      end else if ((branch_taken || jump) && !m_ds) begin
         tgt = branch_taken ? branch_target : jump_target;
         tgt[1:0] = 2'b00;
         m_pc = m_npc; m_npc = tgt; m_ds = 1;
      end else begin
         if (branch_taken || jump) m_err = 1;
         m_pc = m_npc; m_npc = m_npc + 32'd4; m_ds = 0;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Reset = 0; hazard_stall = 0; branch_taken = 0; jump = 0; exception_req = 0;
      branch_target = '0; jump_target = '0;
   endtask

   task automatic do_reset();
      idle(); Reset = 1; tick(); tick(); Reset = 0; tick();
   endtask

   task automatic test_reset();
      idle(); Reset = 1; tick(); tick();
      n_vec++; if (pc !== 32'h0 || npc !== 32'h4) begin n_err++; $display("FAIL reset_pc got %h/%h exp 0/4", pc, npc); end
      n_vec++; if (fetch_valid !== 0 || delay_slot !== 0 || seq_error !== 0 || stall_count !== 16'h0) begin
         n_err++; $display("FAIL reset_flags got fv=%b ds=%b err=%b cnt=%h exp 0", fetch_valid, delay_slot, seq_error, stall_count); end
      Reset = 0;
      // The BOOT cycle holds pc at 0; fetch_valid rises once RUN is entered.
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (pc !== 32'(4*i) || npc !== 32'(4*i+4) || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL freerun_%0d got pc=%h npc=%h fv=%b exp pc=%h npc=%h fv=1", i, pc, npc, fetch_valid, 4*i, 4*i+4); end
      end
   endtask

   task automatic test_branch();
      do_reset(); tick(); tick();
      n_vec++; if (pc !== 32'h8 || npc !== 32'hC) begin n_err++; $display("FAIL br_setup got %h/%h exp 8/c", pc, npc); end
      branch_taken = 1; branch_target = 32'h40; tick(); idle();
      n_vec++; if (pc !== 32'hC || npc !== 32'h40 || delay_slot !== 1'b1) begin
         n_err++; $display("FAIL br_slot got pc=%h npc=%h ds=%b exp c/40/1", pc, npc, delay_slot); end
      tick();
      n_vec++; if (pc !== 32'h40 || npc !== 32'h44 || delay_slot !== 1'b0) begin
         n_err++; $display("FAIL br_target got pc=%h npc=%h ds=%b exp 40/44/0", pc, npc, delay_slot); end
   endtask

   task automatic test_stall();
      do_reset(); repeat (4) tick();
      hazard_stall = 1; repeat (3) tick();
      n_vec++; if (pc !== 32'h10 || npc !== 32'h14 || stall_count !== 16'd3) begin
         n_err++; $display("FAIL stall3 got pc=%h npc=%h cnt=%0d exp 10/14/3", pc, npc, stall_count); end
      repeat (70000) tick();
      n_vec++; if (stall_count !== 16'hFFFF || pc !== 32'h10) begin
         n_err++; $display("FAIL stall_sat got cnt=%h pc=%h exp ffff/10", stall_count, pc); end
      idle(); tick();
      n_vec++; if (pc !== 32'h14 || stall_count !== 16'hFFFF) begin
         n_err++; $display("FAIL stall_release got pc=%h cnt=%h exp 14/ffff", pc, stall_count); end
   endtask

   task automatic test_exception();
      do_reset(); repeat (8) tick();
      n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL exc_setup got %h exp 20", pc); end
      exception_req = 1; hazard_stall = 1; tick(); idle();
      n_vec++; if (pc !== 32'h80 || npc !== 32'h84 || fetch_valid !== 1'b0 || stall_count !== 16'd0) begin
         n_err++; $display("FAIL exc_vec got pc=%h npc=%h fv=%b cnt=%0d exp 80/84/0/0", pc, npc, fetch_valid, stall_count); end
      hazard_stall = 1; jump = 1; jump_target = 32'h300; tick(); idle();
      n_vec++; if (pc !== 32'h80 || fetch_valid !== 1'b1 || stall_count !== 16'd0) begin
         n_err++; $display("FAIL exc_flush_end got pc=%h fv=%b cnt=%0d exp 80/1/0", pc, fetch_valid, stall_count); end
      tick();
      n_vec++; if (pc !== 32'h84 || npc !== 32'h88) begin n_err++; $display("FAIL exc_seq got %h/%h exp 84/88", pc, npc); end
      exception_req = 1; tick(); tick(); exception_req = 0;
      n_vec++; if (fetch_valid !== 1'b0 || pc !== 32'h80) begin n_err++; $display("FAIL exc_reflush got fv=%b pc=%h exp 0/80", fetch_valid, pc); end
      tick();
      n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL exc_reflush_end got fv=%b exp 1", fetch_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      jump = 1; jump_target = 32'h103; tick(); idle();
      n_vec++; if (pc !== 32'h4 || npc !== 32'h100 || delay_slot !== 1'b1) begin
         n_err++; $display("FAIL b2b_jump got pc=%h npc=%h ds=%b exp 4/100/1", pc, npc, delay_slot); end
      branch_taken = 1; branch_target = 32'h200; tick(); idle();
      n_vec++; if (pc !== 32'h100 || npc !== 32'h104 || seq_error !== 1'b1) begin
         n_err++; $display("FAIL b2b_ignored got pc=%h npc=%h err=%b exp 100/104/1", pc, npc, seq_error); end
      repeat (3) tick();
      n_vec++; if (pc !== 32'h10C || seq_error !== 1'b1) begin n_err++; $display("FAIL b2b_sticky got pc=%h err=%b exp 10c/1", pc, seq_error); end
      branch_taken = 1; branch_target = 32'h500; jump = 1; jump_target = 32'h600; tick(); idle();
      n_vec++; if (npc !== 32'h500) begin n_err++; $display("FAIL both_redirect got npc=%h exp 500", npc); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      jump = 1; jump_target = 32'hFFFF_FFF8; tick(); idle(); tick(); tick();
      n_vec++; if (pc !== 32'hFFFF_FFFC || npc !== 32'h0) begin n_err++; $display("FAIL wrap got %h/%h exp fffffffc/0", pc, npc); end
      exception_req = 1; tick(); idle();
      Reset = 1; tick(); Reset = 0;
      n_vec++; if (pc !== 32'h0 || npc !== 32'h4 || fetch_valid !== 1'b0 || seq_error !== 1'b0) begin
         n_err++; $display("FAIL flush_reset got pc=%h npc=%h fv=%b err=%b exp 0/4/0/0", pc, npc, fetch_valid, seq_error); end
      tick();
      n_vec++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL flush_reset_boot got pc=%h fv=%b exp 0/1", pc, fetch_valid); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         Reset         = ($urandom_range(0, 99) < 2);
         exception_req = ($urandom_range(0, 99) < 5);
         hazard_stall  = ($urandom_range(0, 99) < 20);
         branch_taken  = ($urandom_range(0, 99) < 25);
         jump          = ($urandom_range(0, 99) < 15);
         branch_target = $urandom;
         jump_target   = $urandom;
         tick();
         n_vec++; if (pc !== m_pc || npc !== m_npc || fetch_valid !== (m_mode == 1) || delay_slot !== m_ds
                      || seq_error !== m_err || stall_count !== 16'(m_stalls)) begin
            n_err++; $display("FAIL rand_%0d got pc=%h npc=%h fv=%b ds=%b err=%b cnt=%0d exp pc=%h npc=%h fv=%b ds=%b err=%b cnt=%0d",
               i, pc, npc, fetch_valid, delay_slot, seq_error, stall_count, m_pc, m_npc, (m_mode == 1), m_ds, m_err, m_stalls);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_branch();
      test_stall();
      test_exception();
      test_back_to_back();
      test_wrap_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
